// File: rtl/exc_flush_ctrl_pkg.sv
// Shared encodings for the WB-stage exception/flush sequencer.
package exc_flush_ctrl_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  localparam logic [4:0] EXCODE_INT  = 5'h00;
  localparam logic [4:0] EXCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCODE_ADES = 5'h05;
  localparam logic [4:0] EXCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCODE_BP   = 5'h09;
  localparam logic [4:0] EXCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCODE_OV   = 5'h0c;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_INT  = 2'd1;
  localparam logic [1:0] KIND_EXC  = 2'd2;
  localparam logic [1:0] KIND_ERET = 2'd3;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority select of the WB event kind: interrupt over exception over eret.
module exc_prio_enc
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [4:0] INT_EXCODE = EXCODE_INT
) (
  input  logic       int_pending,
  input  logic       ws_ex,
  input  logic       ws_eret,
  input  logic [4:0] ws_excode,
  output logic [1:0] kind,
  output logic [4:0] code
);

  always_comb begin
    kind = KIND_NONE;
    code = 5'd0;
    if (int_pending) begin
      kind = KIND_INT;
      code = INT_EXCODE;
    end else if (ws_ex) begin
      kind = KIND_EXC;
      code = ws_excode;
    end else if (ws_eret) begin
      kind = KIND_ERET;
      code = ws_excode;
    end
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Takes precise WB events, pulses CP0 and flush, then holds a redirect to IF until accepted.
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [4:0]  INT_EXCODE = EXCODE_INT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_eret,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic [31:0] ws_badvaddr,
  input  logic        int_pending,
  input  logic [31:0] cp0_epc,
  output logic        wb_cancel,
  output logic        cp0_ex_we,
  output logic [4:0]  cp0_ex_code,
  output logic [31:0] cp0_ex_pc,
  output logic        cp0_ex_bd,
  output logic [31:0] cp0_ex_badvaddr,
  output logic        cp0_eret_we,
  output logic        flush,
  output logic        fs_redirect_valid,
  output logic [31:0] fs_redirect_pc,
  input  logic        fs_redirect_ready,
  output logic        busy
);

  logic [1:0]  state, state_next;
  logic [1:0]  evt_kind;
  logic [4:0]  evt_code;
  logic        evt;

  logic [1:0]  kind_q;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] badvaddr_q;
  logic [31:0] target_q;

  exc_prio_enc #(
    .INT_EXCODE (INT_EXCODE)
  ) u_prio (
    .int_pending (int_pending),
    .ws_ex       (ws_ex),
    .ws_eret     (ws_eret),
    .ws_excode   (ws_excode),
    .kind        (evt_kind),
    .code        (evt_code)
  );

  // Reset gating keeps wb_cancel quiet while the pipeline is held in reset.
  assign evt = ~reset & (state == S_IDLE) & ws_valid & (evt_kind != KIND_NONE);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (evt) state_next = S_FLUSH;
      S_FLUSH:    state_next = S_REDIRECT;
      S_REDIRECT: if (fs_redirect_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      kind_q     <= KIND_NONE;
      code_q     <= 5'd0;
      pc_q       <= 32'd0;
      bd_q       <= 1'b0;
      badvaddr_q <= 32'd0;
      target_q   <= 32'd0;
    end else begin
      state <= state_next;
      if (evt) begin
        kind_q     <= evt_kind;
        code_q     <= evt_code;
        pc_q       <= ws_pc;
        bd_q       <= ws_bd;
        badvaddr_q <= ws_badvaddr;
        // EPC is taken before this block's own CP0 write can disturb it.
        target_q   <= (evt_kind == KIND_ERET) ? cp0_epc : EXC_VECTOR;
      end
    end
  end

  always_comb begin
    wb_cancel         = evt;
    flush             = (state == S_FLUSH);
    cp0_ex_we         = flush & (kind_q != KIND_ERET);
    cp0_eret_we       = flush & (kind_q == KIND_ERET);
    cp0_ex_code       = cp0_ex_we ? code_q : 5'd0;
    cp0_ex_pc         = cp0_ex_we ? pc_q : 32'd0;
    cp0_ex_bd         = cp0_ex_we & bd_q;
    cp0_ex_badvaddr   = cp0_ex_we ? badvaddr_q : 32'd0;
    fs_redirect_valid = (state == S_REDIRECT);
    fs_redirect_pc    = fs_redirect_valid ? target_q : 32'd0;
    busy              = (state != S_IDLE);
  end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed plus randomized event sequences checked against a transaction-level timeline model.
module tb_exc_flush_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_ex, ws_eret, ws_bd, int_pending;
  logic [4:0]  ws_excode;
  logic [31:0] ws_pc, ws_badvaddr, cp0_epc;
  logic        wb_cancel, cp0_ex_we, cp0_ex_bd, cp0_eret_we, flush;
  logic [4:0]  cp0_ex_code;
  logic [31:0] cp0_ex_pc, cp0_ex_badvaddr, fs_redirect_pc;
  logic        fs_redirect_valid, fs_redirect_ready, busy;
  logic [107:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_flush_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .ws_valid          (ws_valid),
    .ws_ex             (ws_ex),
    .ws_excode         (ws_excode),
    .ws_eret           (ws_eret),
    .ws_pc             (ws_pc),
    .ws_bd             (ws_bd),
    .ws_badvaddr       (ws_badvaddr),
    .int_pending       (int_pending),
    .cp0_epc           (cp0_epc),
    .wb_cancel         (wb_cancel),
    .cp0_ex_we         (cp0_ex_we),
    .cp0_ex_code       (cp0_ex_code),
    .cp0_ex_pc         (cp0_ex_pc),
    .cp0_ex_bd         (cp0_ex_bd),
    .cp0_ex_badvaddr   (cp0_ex_badvaddr),
    .cp0_eret_we       (cp0_eret_we),
    .flush             (flush),
    .fs_redirect_valid (fs_redirect_valid),
    .fs_redirect_pc    (fs_redirect_pc),
    .fs_redirect_ready (fs_redirect_ready),
    .busy              (busy)
  );

  assign obs = {wb_cancel, cp0_ex_we, cp0_ex_code, cp0_ex_pc, cp0_ex_bd, cp0_ex_badvaddr,
                cp0_eret_we, flush, fs_redirect_valid, fs_redirect_pc, busy};

  function automatic logic [107:0] ev(input logic cancel, input logic ex_we,
                                      input logic [4:0] code, input logic [31:0] pc,
                                      input logic bd, input logic [31:0] bad,
                                      input logic eret_we, input logic fl, input logic rv,
                                      input logic [31:0] rpc, input logic bsy);
    return {cancel, ex_we, code, pc, bd, bad, eret_we, fl, rv, rpc, bsy};
  endfunction

  task automatic check(input string tag, input logic [107:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic quiet();
    ws_valid = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0; ws_bd = 1'b0; int_pending = 1'b0;
    ws_excode = 5'd0; ws_pc = 32'd0; ws_badvaddr = 32'd0; fs_redirect_ready = 1'b0;
  endtask

  task automatic noise_inputs();
    ws_valid = 1'b1; ws_ex = 1'($urandom); ws_eret = 1'($urandom);
    int_pending = 1'($urandom); ws_bd = 1'($urandom); ws_excode = 5'($urandom);
    ws_pc = $urandom; ws_badvaddr = $urandom; cp0_epc = $urandom;
    fs_redirect_ready = 1'($urandom);
  endtask

  // Presents one WB cycle and, if it is an event, follows the whole expected timeline.
  task automatic run_event(input string tag, input logic v, input logic ex,
                           input logic [4:0] code, input logic eret, input logic intp,
                           input logic [31:0] pc, input logic bd, input logic [31:0] bad,
                           input logic [31:0] epc, input int delay, input bit noise,
                           input bit rst_in_redirect);
    logic        is_evt, is_eret;
    logic [4:0]  ecode;
    logic [31:0] tgt;
    @(posedge clk); #1;
    ws_valid = v; ws_ex = ex; ws_excode = code; ws_eret = eret; int_pending = intp;
    ws_pc = pc; ws_bd = bd; ws_badvaddr = bad; cp0_epc = epc;
    fs_redirect_ready = 1'($urandom);
    is_evt = v && (intp || ex || eret);
    #3;
    check({tag, ":cancel"}, ev(is_evt, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (!is_evt) return;

    is_eret = 1'b0;
    if (intp) begin
      ecode = 5'h00; tgt = VEC;
    end else if (ex) begin
      ecode = code; tgt = VEC;
    end else begin
      ecode = 5'h00; tgt = epc; is_eret = 1'b1;
    end

    @(posedge clk); #1;
    if (noise) noise_inputs(); else quiet();
    #3;
    if (is_eret) check({tag, ":flush"}, ev(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    else         check({tag, ":flush"}, ev(0, 1, ecode, pc, bd, bad, 0, 1, 0, 0, 1));

    for (int k = 0; k <= delay; k++) begin
      @(posedge clk); #1;
      if (noise) noise_inputs(); else quiet();
      fs_redirect_ready = (k == delay);
      if (rst_in_redirect) reset = 1'b1;
      #3;
      check({tag, ":redirect"}, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, tgt, 1));
      if (rst_in_redirect) begin
        @(posedge clk); #1;
        reset = 1'b0;
        quiet();
        #3;
        check({tag, ":after_reset"}, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        return;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    cp0_epc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    ws_valid = 1'b1; ws_ex = 1'b1; int_pending = 1'b1;
    #3;
    check("reset_outputs", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    quiet();
    reset = 1'b0;

    run_event("exc_imm", 1, 1, 5'h0a, 0, 0, 32'hBFC00100, 0, 32'h0, 32'h0, 0, 0, 0);
    run_event("idle_after_exc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_event("eret_delay", 1, 0, 5'h00, 1, 0, 32'hBFC00040, 0, 32'h0, 32'hBFC00204, 4, 0, 0);
    run_event("int_eret", 1, 0, 5'h1f, 1, 1, 32'hBFC00300, 0, 32'h0, 32'h12345678, 1, 0, 0);
    run_event("ds_exc", 1, 1, 5'h04, 0, 0, 32'hBFC00500, 1, 32'h00000003, 32'h0, 0, 0, 0);
    run_event("busy_ignore", 1, 1, 5'h0c, 0, 0, 32'hBFC00600, 0, 32'h0, 32'h0, 3, 1, 0);
    run_event("back_to_back", 1, 1, 5'h08, 0, 0, 32'hBFC00700, 0, 32'h0, 32'h0, 0, 0, 0);
    run_event("invalid_ws", 0, 1, 5'h09, 1, 1, 32'hBFC00800, 0, 32'h0, 32'h0, 0, 0, 0);
    run_event("rst_redirect", 1, 1, 5'h05, 0, 0, 32'hBFC00900, 1, 32'h44, 32'h0, 2, 0, 1);
    run_event("post_reset", 1, 1, 5'h09, 0, 0, 32'hBFC00A00, 0, 32'h0, 32'h0, 1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      run_event("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                $urandom_range(0, 3), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_flush_ctrl.md
# exc_flush_ctrl

Exception/flush sequencer between the write-back stage, CP0 and the fetch stage of the five-stage MIPS pipeline. It takes precise events at WB: a synchronous exception, `eret`, or a sampled external interrupt. For each event it:
- cancels the WB register write,
- issues a one-cycle CP0 update,
- flushes every stage,
- holds a redirect request to IF until IF accepts it.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, exception/interrupt entry PC
- INT_EXCODE, 5'h00, ExcCode written for interrupts

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_valid  in  1  WB holds a valid instruction
- ws_ex  in  1  WB instruction carries an exception
- ws_excode  in  5  its ExcCode
- ws_eret  in  1  WB instruction is `eret`
- ws_pc  in  32  WB instruction PC
- ws_bd  in  1  WB instruction is in a delay slot
- ws_badvaddr  in  32  faulting address from WB
- int_pending  in  1  from CP0: Status.IE & ~Status.EXL & |(IM & IP)
- cp0_epc  in  32  current EPC
- wb_cancel  out  1  suppress WB register-file write this cycle
- cp0_ex_we  out  1  one-cycle pulse: CP0 records an exception
- cp0_ex_code  out  5  ExcCode for CP0
- cp0_ex_pc  out  32  EPC candidate
- cp0_ex_bd  out  1  Cause.BD
- cp0_ex_badvaddr  out  32  BadVAddr
- cp0_eret_we  out  1  one-cycle pulse: CP0 clears Status.EXL
- flush  out  1  one-cycle pulse: squash IF/ID/EX/MEM/WB valid bits
- fs_redirect_valid  out  1  redirect request to IF
- fs_redirect_pc  out  32  redirect target
- fs_redirect_ready  in  1  IF accepts the redirect
- busy  out  1  controller is not in IDLE; ID must not issue

## Operation
- **States:** IDLE, FLUSH, REDIRECT.
- **Event detection (IDLE only):** `evt = ws_valid & (int_pending | ws_ex | ws_eret)`.
- **Event priority:** int_pending > ws_ex > ws_eret. An interrupt coinciding with `eret` takes the interrupt; the `eret` is not executed.
- **wb_cancel:** combinational, equal to `evt` in IDLE and 0 in any other state. It also applies to an interrupted instruction, which must not commit.
- **Capture on evt (IDLE→FLUSH):** latch the following.
  - kind: INT, EXC or ERET.
  - code: INT_EXCODE for INT, otherwise ws_excode.
  - ws_pc, ws_bd, ws_badvaddr.
  - target: EXC_VECTOR for INT/EXC; cp0_epc sampled this cycle for ERET.
- **FLUSH (one cycle):**
  - flush=1.
  - For INT/EXC: cp0_ex_we=1, with cp0_ex_* driven from the latched values.
  - For ERET: cp0_eret_we=1.
  - Next state is REDIRECT unconditionally.
- **REDIRECT:**
  - fs_redirect_valid=1; fs_redirect_pc holds the latched target.
  - When fs_redirect_ready=1, return to IDLE.
  - The request stays stable, with no target change, until accepted.
- **Ignored inputs outside IDLE:** ws_* and int_pending are ignored in FLUSH and REDIRECT, because everything in flight is squashed.
- **busy:** 1 in FLUSH and REDIRECT.
- **Unused outputs:** cp0_ex_* are 0 whenever cp0_ex_we=0. fs_redirect_pc is 0 whenever fs_redirect_valid=0.

## Timing
- **Reset:** state=IDLE; all latches clear; every output is 0.
- **Reset mid-sequence:** a reset in FLUSH or REDIRECT returns to IDLE on the next edge. No CP0 pulse and no redirect is emitted after reset.
- **Latency:**
  - Event in cycle N: wb_cancel is asserted in N.
  - flush and CP0 pulse are asserted in N+1.
  - fs_redirect_valid is asserted from N+2.
  - If ready is already high in N+2, IDLE is re-entered at N+3.
- **Minimum spacing:** three cycles between events.
- **Back-to-back handling:** an event presented in the same cycle the FSM returns to IDLE (the cycle after the accepting handshake) is taken normally.
- **ERET target:** cp0_epc is sampled at capture, before any CP0 write by this block.
- **Pulse width:** flush, cp0_ex_we and cp0_eret_we are never high for more than one consecutive cycle.

## Structure
- Add to mycpu.h:
  - state encodings;
  - EXC_VECTOR default;
  - ExcCode constants (Int=0x00, AdEL=0x04, AdES=0x05, Sys=0x08, Bp=0x09, RI=0x0a, Ov=0x0c);
  - event-kind encoding.
- One sub-module, `exc_prio_enc`: combinational priority select of kind/code from int_pending, ws_ex, ws_eret.
- FSM, capture registers and output muxing live in exc_flush_ctrl.

## Test plan
- **Exception with immediate accept:**
  - Stimulus: ws_valid=1, ws_ex=1, ws_excode=0x0a, ws_pc=0xBFC00100, ws_bd=0, fs_redirect_ready=1.
  - Response: wb_cancel in N; flush and cp0_ex_we with code 0x0a and pc 0xBFC00100 in N+1; redirect to 0xBFC00380 in N+2; busy=0 at N+3.
- **ERET with delayed accept:**
  - Stimulus: ws_eret=1, cp0_epc=0xBFC00204; ready held low 4 cycles.
  - Response: cp0_eret_we once at N+1; redirect_valid stays high with pc 0xBFC00204 for 5 cycles; one accept returns to IDLE.
- **Simultaneous interrupt and eret:**
  - Stimulus: int_pending=1 with ws_eret=1 and ws_pc=0xBFC00300.
  - Response: cp0_ex_we with code 0x00 and pc 0xBFC00300; no cp0_eret_we; target 0xBFC00380.
- **Delay-slot exception:**
  - Stimulus: ws_ex=1 with ws_bd=1 and ws_badvaddr=0x00000003.
  - Response: cp0_ex_bd=1 and cp0_ex_badvaddr=0x00000003 in the flush cycle.
- **Events ignored while busy:**
  - Stimulus: a new ws_ex and int_pending during FLUSH/REDIRECT.
  - Response: no second flush or CP0 pulse; wb_cancel=0.
- **Reset in REDIRECT:**
  - Stimulus: assert reset while in REDIRECT.
  - Response: next cycle all outputs are 0 and busy=0; a following exception sequences normally.
